// File: rtl/prbs7_pkg.sv
// Shared definitions for the PRBS7 generator/checker pair: state encoding,
// LFSR taps and the feedback function used by both ends of the link.
package prbs7_pkg;

    typedef enum logic [1:0] {
        SEED,
        HUNT,
        LOCKED
    } prbs_state_t;

    localparam int TAP_HI   = 6;
    localparam int TAP_LO   = 2;
    localparam int PRBS_LEN = 7;

    // Feedback bit appended at the LSB by the generator on every shift.
    function automatic logic prbs7_next(input logic [PRBS_LEN-1:0] s);
        return s[TAP_HI] ^ s[TAP_LO];
    endfunction

endpackage

// File: rtl/prbs7_checker_if.sv
// Bit-stream input and status/count outputs of the PRBS7 checker.
interface prbs7_checker_if #(
    parameter int CNT_W = 16
) ();

    logic             en;
    logic             bit_in;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] bit_count;

    modport master (
        output en,
        output bit_in,
        output clr_cnt,
        input  locked,
        input  err_pulse,
        input  err_count,
        input  bit_count
    );

    modport slave (
        input  en,
        input  bit_in,
        input  clr_cnt,
        output locked,
        output err_pulse,
        output err_count,
        output bit_count
    );

endinterface

// File: rtl/prbs7_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;
    logic [W-1:0] q_next;

    always_comb begin
        q_next = q_reg;
        if (clr) begin
            q_next = '0;
        end else if (inc && (q_reg != '1)) begin
            q_next = q_reg + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/prbs7_checker.sv
// PRBS7 receive checker: seeds a predictor from the incoming stream, hunts for
// a run of correct predictions, then free-runs and counts bit errors.
module prbs7_checker
    import prbs7_pkg::*;
#(
    parameter int LOCK_MATCHES = 16,
    parameter int LOSS_ERRS    = 4,
    parameter int LOSS_WIN     = 64,
    parameter int CNT_W        = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    prbs7_checker_if.slave  bus
);

    localparam int FILL_W  = $clog2(PRBS_LEN + 1);
    localparam int MATCH_W = $clog2(LOCK_MATCHES + 1);
    localparam int WBIT_W  = $clog2(LOSS_WIN);
    localparam int WERR_W  = $clog2(LOSS_ERRS + 1);

    localparam logic [FILL_W-1:0]  FILL_LAST   = FILL_W'(PRBS_LEN - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST  = MATCH_W'(LOCK_MATCHES - 1);
    localparam logic [WBIT_W-1:0]  WBIT_LAST   = WBIT_W'(LOSS_WIN - 1);
    localparam logic [WERR_W-1:0]  WERR_LIMIT  = WERR_W'(LOSS_ERRS);

    prbs_state_t          state_reg;
    prbs_state_t          state_next;
    logic [PRBS_LEN-1:0]  r_reg;
    logic [PRBS_LEN-1:0]  r_next;
    logic [FILL_W-1:0]    fill_reg;
    logic [FILL_W-1:0]    fill_next;
    logic [MATCH_W-1:0]   match_reg;
    logic [MATCH_W-1:0]   match_next;
    logic [WBIT_W-1:0]    wbit_reg;
    logic [WBIT_W-1:0]    wbit_next;
    logic [WERR_W-1:0]    werr_reg;
    logic [WERR_W-1:0]    werr_next;
    logic [WERR_W-1:0]    werr_sum;
    logic                 locked_reg;
    logic                 err_pulse_reg;
    logic                 err_pulse_next;

    logic                 exp_bit;
    logic                 mismatch;
    logic                 err_inc;
    logic                 bit_inc;
    logic [CNT_W-1:0]     err_count_w;
    logic [CNT_W-1:0]     bit_count_w;

    assign exp_bit  = prbs7_next(r_reg);
    assign mismatch = bus.bit_in ^ exp_bit;

    always_comb begin
        state_next     = state_reg;
        r_next         = r_reg;
        fill_next      = fill_reg;
        match_next     = match_reg;
        wbit_next      = wbit_reg;
        werr_next      = werr_reg;
        werr_sum       = werr_reg;
        err_pulse_next = 1'b0;
        err_inc        = 1'b0;
        bit_inc        = 1'b0;

        if (bus.en) begin
            case (state_reg)
                SEED: begin
                    r_next = {r_reg[PRBS_LEN-2:0], bus.bit_in};
                    if (fill_reg == FILL_LAST) begin
                        state_next = HUNT;
                        fill_next  = '0;
                        match_next = '0;
                    end else begin
                        fill_next = fill_reg + FILL_W'(1);
                    end
                end

                HUNT: begin
                    r_next = {r_reg[PRBS_LEN-2:0], bus.bit_in};
                    // An all-zero predictor reproduces a zero stream forever; never trust it.
                    if (!mismatch && (r_reg != '0)) begin
                        if (match_reg == MATCH_LAST) begin
                            state_next = LOCKED;
                            match_next = '0;
                            wbit_next  = '0;
                            werr_next  = '0;
                        end else begin
                            match_next = match_reg + MATCH_W'(1);
                        end
                    end else begin
                        match_next = '0;
                    end
                end

                LOCKED: begin
                    // Free-running predictor: a corrupted input bit never enters r.
                    r_next         = {r_reg[PRBS_LEN-2:0], exp_bit};
                    bit_inc        = 1'b1;
                    err_inc        = mismatch;
                    err_pulse_next = mismatch;
                    if (wbit_reg == WBIT_LAST) begin
                        wbit_next = '0;
                        werr_sum  = WERR_W'(mismatch);
                    end else begin
                        wbit_next = wbit_reg + WBIT_W'(1);
                        werr_sum  = werr_reg + WERR_W'(mismatch);
                    end
                    werr_next = werr_sum;
                    if (werr_sum == WERR_LIMIT) begin
                        state_next = SEED;
                        r_next     = '0;
                        fill_next  = '0;
                    end
                end

                default: begin
                    state_next = SEED;
                    r_next     = '0;
                    fill_next  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= SEED;
            r_reg         <= '0;
            fill_reg      <= '0;
            match_reg     <= '0;
            wbit_reg      <= '0;
            werr_reg      <= '0;
            locked_reg    <= 1'b0;
            err_pulse_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            r_reg         <= r_next;
            fill_reg      <= fill_next;
            match_reg     <= match_next;
            wbit_reg      <= wbit_next;
            werr_reg      <= werr_next;
            locked_reg    <= (state_next == LOCKED);
            err_pulse_reg <= err_pulse_next;
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_inc),
        .clr   (bus.clr_cnt),
        .q     (err_count_w)
    );

    sat_counter #(.W(CNT_W)) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bit_inc),
        .clr   (bus.clr_cnt),
        .q     (bit_count_w)
    );

    assign bus.locked    = locked_reg;
    assign bus.err_pulse = err_pulse_reg;
    assign bus.err_count = err_count_w;
    assign bus.bit_count = bit_count_w;

endmodule

// File: tb/tb_prbs7_checker.sv
// Self-checking bench for prbs7_checker: directed lock/loss scenarios plus a
// randomized stream, compared every cycle against a bit-history reference model.
module tb_prbs7_checker;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prbs7_checker_if #(.CNT_W(16)) ifc ();

    prbs7_checker #(
        .LOCK_MATCHES (16),
        .LOSS_ERRS    (4),
        .LOSS_WIN     (64),
        .CNT_W        (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int       total = 0;
    int       bad   = 0;
    bit       chk_on = 1'b0;
    bit [6:0] gen_s;
    int       vb;

    // Reference model state: the last 7 reference bits, run of good predictions,
    // lock flag, bits since lock, current window id and its error tally.
    bit hist[$];
    int m_run;
    bit m_locked;
    int m_k;
    int m_grp;
    int m_grp_err;
    int m_err;
    int m_bits;
    bit m_pulse;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic bit gen_next();
        bit fb;
        fb    = gen_s[6] ^ gen_s[2];
        gen_s = {gen_s[5:0], fb};
        return fb;
    endfunction

    function automatic void model_reset();
        hist.delete();
        m_run = 0; m_locked = 0; m_k = 0; m_grp = 0; m_grp_err = 0;
        m_err = 0; m_bits = 0; m_pulse = 0;
    endfunction

    // PRBS7 recurrence: bit[i] = bit[i-3] ^ bit[i-7].
    function automatic void model_step(input bit en, input bit b, input bit clr);
        bit pred;
        bit nz;
        bit e;
        int n;
        int g;
        m_pulse = 0;
        if (en) begin
            n = hist.size();
            if (!m_locked) begin
                if (n >= 7) begin
                    pred = hist[n-3] ^ hist[n-7];
                    nz = 0;
                    for (int i = n - 7; i < n; i++) nz |= hist[i];
                    if (b == pred && nz) m_run++;
                    else m_run = 0;
                end
                hist.push_back(b);
                if (m_run == 16) begin
                    m_locked = 1; m_run = 0; m_k = 0; m_grp = 0; m_grp_err = 0;
                end
            end else begin
                pred = hist[n-3] ^ hist[n-7];
                hist.push_back(pred);
                e = (b != pred);
                if (m_bits < 65535) m_bits++;
                if (e) begin
                    if (m_err < 65535) m_err++;
                    m_pulse = 1;
                end
                g = (m_k + 1) / 64;
                if (g != m_grp) begin
                    m_grp = g;
                    m_grp_err = 0;
                end
                if (e) m_grp_err++;
                m_k++;
                if (m_grp_err >= 4) begin
                    m_locked = 0;
                    m_run = 0;
                    hist.delete();
                end
            end
            while (hist.size() > 7) void'(hist.pop_front());
        end
        if (clr) begin
            m_err = 0;
            m_bits = 0;
        end
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            chk("locked",    32'(ifc.locked),    32'(m_locked));
            chk("err_pulse", 32'(ifc.err_pulse), 32'(m_pulse));
            chk("err_count", 32'(ifc.err_count), 32'(m_err));
            chk("bit_count", 32'(ifc.bit_count), 32'(m_bits));
        end
    end

    task automatic cycle_raw(input bit en, input bit b, input bit clr);
        ifc.en      = en;
        ifc.bit_in  = b;
        ifc.clr_cnt = clr;
        @(posedge clk);
        model_step(en, b, clr);
        if (en) vb++;
        @(negedge clk);
    endtask

    task automatic cycle(input bit en, input bit flip, input bit clr);
        bit b;
        if (en) b = gen_next() ^ flip;
        else    b = 1'($urandom);
        cycle_raw(en, b, clr);
        if (flip) $display("flip at valid bit %0d: err_pulse=%0b locked=%0b err_count=%0d",
                           vb, ifc.err_pulse, ifc.locked, ifc.err_count);
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        chk_on      = 1'b0;
        ifc.en      = 1'b0;
        ifc.bit_in  = 1'b0;
        ifc.clr_cnt = 1'b0;
        rst_n       = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_locked",    32'(ifc.locked),    32'd0);
        chk("rst_err_pulse", 32'(ifc.err_pulse), 32'd0);
        chk("rst_err_count", 32'(ifc.err_count), 32'd0);
        chk("rst_bit_count", 32'(ifc.bit_count), 32'd0);
        rst_n = 1'b1;
        model_reset();
        gen_s  = 7'b1;
        vb     = 0;
        chk_on = 1'b1;
    endtask

    initial begin
        int lock_vb;

        // 1: clean stream locks after valid bit 23, counts bits afterwards
        do_reset();
        clean(22);
        chk("t1_not_locked_22", 32'(ifc.locked), 32'd0);
        clean(1);
        chk("t1_locked_23", 32'(ifc.locked), 32'd1);
        clean(77);
        chk("t1_err_count", 32'(ifc.err_count), 32'd0);
        chk("t1_bit_count", 32'(ifc.bit_count), 32'd77);
        $display("test1: lock at bit 23, bit_count=%0d", ifc.bit_count);

        // 2: single error at bit 40
        do_reset();
        clean(39);
        cycle(1'b1, 1'b1, 1'b0);
        chk("t2_pulse", 32'(ifc.err_pulse), 32'd1);
        clean(1);
        chk("t2_pulse_drop", 32'(ifc.err_pulse), 32'd0);
        clean(100);
        chk("t2_err_count", 32'(ifc.err_count), 32'd1);
        chk("t2_locked", 32'(ifc.locked), 32'd1);

        // 3: four errors in one window drop lock, relock 23 bits later
        do_reset();
        clean(23);
        clean(5);  cycle(1'b1, 1'b1, 1'b0);
        clean(4);  cycle(1'b1, 1'b1, 1'b0);
        clean(4);  cycle(1'b1, 1'b1, 1'b0);
        chk("t3_locked_after_3", 32'(ifc.locked), 32'd1);
        clean(4);  cycle(1'b1, 1'b1, 1'b0);
        chk("t3_unlocked", 32'(ifc.locked), 32'd0);
        chk("t3_err_count", 32'(ifc.err_count), 32'd4);
        clean(22);
        chk("t3_not_yet", 32'(ifc.locked), 32'd0);
        clean(1);
        chk("t3_relocked", 32'(ifc.locked), 32'd1);
        chk("t3_err_kept", 32'(ifc.err_count), 32'd4);

        // 4: 3 errors in window 0, one in the wrap bit (counts in window 1), then 4th in window 1
        do_reset();
        clean(23);
        clean(50); cycle(1'b1, 1'b1, 1'b0);
        clean(4);  cycle(1'b1, 1'b1, 1'b0);
        clean(4);  cycle(1'b1, 1'b1, 1'b0);
        clean(2);  cycle(1'b1, 1'b1, 1'b0);
        chk("t4_locked", 32'(ifc.locked), 32'd1);
        chk("t4_err_count", 32'(ifc.err_count), 32'd4);
        clean(6);  cycle(1'b1, 1'b1, 1'b0);
        clean(9);  cycle(1'b1, 1'b1, 1'b0);
        chk("t4_still_locked", 32'(ifc.locked), 32'd1);
        clean(9);  cycle(1'b1, 1'b1, 1'b0);
        chk("t4_unlocked", 32'(ifc.locked), 32'd0);
        chk("t4_err_count2", 32'(ifc.err_count), 32'd7);

        // 5: all-zero input never locks; a real stream then locks
        do_reset();
        for (int i = 0; i < 200; i++) cycle_raw(1'b1, 1'b0, 1'b0);
        chk("t5_zero_unlocked", 32'(ifc.locked), 32'd0);
        gen_s = 7'b1;
        clean(23);
        chk("t5_locked", 32'(ifc.locked), 32'd1);

        // 6: random en stalls do not change the lock bit index
        do_reset();
        lock_vb = -1;
        for (int i = 0; i < 300 && lock_vb < 0; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            if (ifc.locked === 1'b1) lock_vb = vb;
        end
        chk("t6_lock_index", 32'(lock_vb), 32'd23);
        clean(10);

        // asynchronous reset mid-cycle while locked
        chk_on = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_arst_locked",    32'(ifc.locked),    32'd0);
        chk("t6_arst_err_count", 32'(ifc.err_count), 32'd0);
        chk("t6_arst_bit_count", 32'(ifc.bit_count), 32'd0);
        chk("t6_arst_pulse",     32'(ifc.err_pulse), 32'd0);

        // clr_cnt coincident with an error
        do_reset();
        clean(28);
        cycle(1'b1, 1'b1, 1'b1);
        chk("t6_clr_pulse", 32'(ifc.err_pulse), 32'd1);
        chk("t6_clr_err",   32'(ifc.err_count), 32'd0);
        chk("t6_clr_bits",  32'(ifc.bit_count), 32'd0);
        clean(1);
        chk("t6_clr_bits1", 32'(ifc.bit_count), 32'd1);

        // randomized: stalls, sparse errors, occasional clears
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 199) == 0));
        end

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
